// File: rtl/cmp_iter_pkg.sv
// Shared definitions for the iterative comparator: mode codes, FSM states
// and the mapping from the final (eq, lt) pair onto the selected branch condition.
package cmp_iter_pkg;

    localparam logic [2:0] CMP_BEQ  = 3'd0;
    localparam logic [2:0] CMP_BNE  = 3'd1;
    localparam logic [2:0] CMP_BLEZ = 3'd2;
    localparam logic [2:0] CMP_BGTZ = 3'd3;
    localparam logic [2:0] CMP_BLTZ = 3'd4;
    localparam logic [2:0] CMP_BGEZ = 3'd5;
    localparam logic [2:0] CMP_SLT  = 3'd6;
    localparam logic [2:0] CMP_SLTU = 3'd7;

    typedef enum logic [1:0] {
        CMPI_IDLE = 2'd0,
        CMPI_RUN  = 2'd1,
        CMPI_DONE = 2'd2
    } cmpi_state_e;

    function automatic logic is_signed_mode(input logic [2:0] m);
        return (m >= CMP_BLEZ) && (m <= CMP_SLT);
    endfunction

    function automatic logic is_zero_mode(input logic [2:0] m);
        return (m >= CMP_BLEZ) && (m <= CMP_BGEZ);
    endfunction

    function automatic logic mode_result(input logic [2:0] m, input logic eq, input logic lt);
        logic r;
        case (m)
            CMP_BEQ:  r = eq;
            CMP_BNE:  r = ~eq;
            CMP_BLEZ: r = lt | eq;
            CMP_BGTZ: r = ~(lt | eq);
            CMP_BGEZ: r = ~lt;
            default:  r = lt;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational SLICE-bit compare; signed_top flips the slice MSB of both
// operands so an unsigned compare of the top slice orders two's-complement values.
module cmp_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         signed_top,
    output logic         eq,
    output logic         lt
);

    logic [W-1:0] msk;
    logic [W-1:0] a_m;
    logic [W-1:0] b_m;

    always_comb begin
        msk        = '0;
        msk[W-1]   = signed_top;
        a_m        = a ^ msk;
        b_m        = b ^ msk;
        eq         = (a_m == b_m);
        lt         = (a_m < b_m);
    end

endmodule

// File: rtl/cmp_iter.sv
// Iterative MSB-first branch comparator; done pulses N+1 cycles after an accepted start.
// Backpressure: busy is high during RUN and start is ignored then; flush aborts at any time.
module cmp_iter
    import cmp_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             res
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    cmpi_state_e      state_q;
    cmpi_state_e      state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       mode_q;
    logic             eq_q;
    logic             lt_q;
    logic             res_q;

    logic accept;
    logic last;
    logic sl_eq;
    logic sl_lt;
    logic eq_nxt;
    logic lt_nxt;

    assign accept = ((state_q == CMPI_IDLE) || (state_q == CMPI_DONE)) && start && !flush;
    assign last   = (cnt_q == CNT_LAST);

    // Operands shift left each RUN cycle, so the slice under test is always the top one.
    cmp_slice #(.W(SLICE)) u_slice (
        .a          (a_q[WIDTH-1 -: SLICE]),
        .b          (b_q[WIDTH-1 -: SLICE]),
        .signed_top (is_signed_mode(mode_q) && (cnt_q == '0)),
        .eq         (sl_eq),
        .lt         (sl_lt)
    );

    // The first differing slice (MSB side) decides the ordering.
    assign eq_nxt = eq_q & sl_eq;
    assign lt_nxt = (eq_q && !sl_eq) ? sl_lt : lt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CMPI_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = CMPI_IDLE;
        end else begin
            case (state_q)
                CMPI_IDLE: if (start) state_d = CMPI_RUN;
                CMPI_RUN:  if (last)  state_d = CMPI_DONE;
                CMPI_DONE: state_d = start ? CMPI_RUN : CMPI_IDLE;
                default:   state_d = CMPI_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == CMPI_RUN);
        done = (state_q == CMPI_DONE);
        res  = res_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= CMP_BEQ;
            eq_q   <= 1'b1;
            lt_q   <= 1'b0;
            res_q  <= 1'b0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            a_q    <= src_a;
            b_q    <= is_zero_mode(mode) ? '0 : src_b;
            mode_q <= mode;
            cnt_q  <= '0;
            eq_q   <= 1'b1;
            lt_q   <= 1'b0;
        end else if (state_q == CMPI_RUN) begin
            a_q  <= a_q << SLICE;
            b_q  <= b_q << SLICE;
            eq_q <= eq_nxt;
            lt_q <= lt_nxt;
            if (last) begin
                cnt_q <= '0;
                res_q <= mode_result(mode_q, eq_nxt, lt_nxt);
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule
